// File: rtl/song_sequencer_if.sv
// song_sequencer_if
//
// Bundles the control pulses, the shared ROM bus and the playback outputs of
// song_sequencer so they travel together between the sequencer and its
// neighbours.
//
// Control inputs are single-cycle pulses. There is no back-pressure: a pulse is
// seen on exactly one rising clock edge and is either acted on or ignored,
// depending on the sequencer state at that edge.
//
// Signals:
//   play, pause, stop   control pulses (stop > pause > play)
//   song_sel            song choice, latched when play is accepted in IDLE
//   loop_en             wrap to step 0 at end of song
//   rom_addr            shared address to both note ROMs
//   rom1_note/rom2_note registered ROM data, one clock after rom_addr
//   note_out            note to the tone generator, 0 = silence
//   step                index of the step currently sounding
//   busy                high outside IDLE
//   done                one-cycle pulse when a non-looping song ends
//   dbg_state           current sequencer state (IDLE/LOAD/PLAY/PAUSED)
//
// Modports: master = user/ROM side, slave = the sequencer itself.
interface song_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int NOTE_W = 10
);
    logic              play;
    logic              pause;
    logic              stop;
    logic              song_sel;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom1_note;
    logic [NOTE_W-1:0] rom2_note;
    logic [NOTE_W-1:0] note_out;
    logic [ADDR_W-1:0] step;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    modport master (
        output play, pause, stop, song_sel, loop_en, rom1_note, rom2_note,
        input  rom_addr, note_out, step, busy, done, dbg_state
    );

    modport slave (
        input  play, pause, stop, song_sel, loop_en, rom1_note, rom2_note,
        output rom_addr, note_out, step, busy, done, dbg_state
    );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer
//
// Tempo-driven playback controller for two note ROMs sharing one address bus.
// One step is played every TICK_DIV clocks. The address of the next step is
// presented as soon as a step starts, so the ROMs' registered read has settled
// well before the step boundary latches it into the held note.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  song_sequencer_if.slave (controls, ROM bus, playback outputs)
//
// Parameters: TICK_DIV (clocks per step, >= 4), LEN1/LEN2 (song lengths),
// ADDR_W, NOTE_W, ARTIC_CYC (articulation gap length, <= TICK_DIV-3).
//
// Optional feature: define ARTIC_GAP_EN to silence the tail of a step whose
// successor has the same (non-zero) note, so repeats are heard as separate
// notes instead of one sustained tone.
module song_sequencer #(
    parameter int TICK_DIV  = 6250000,
    parameter int LEN1      = 365,
    parameter int LEN2      = 261,
    parameter int ADDR_W    = 10,
    parameter int NOTE_W    = 10,
    parameter int ARTIC_CYC = 500000
) (
    input logic             clk,
    input logic             rst,
    song_sequencer_if.slave bus
);

    localparam int                TICK_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LEN1_A      = ADDR_W'(LEN1);
    localparam logic [ADDR_W-1:0] LEN2_A      = ADDR_W'(LEN2);
    localparam logic [31:0]       ARTIC_START = 32'(TICK_DIV - ARTIC_CYC);

`ifdef ARTIC_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_PLAY   = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              sel_q, sel_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] step_q, step_nx;
    logic [NOTE_W-1:0] held_q, held_nx;
    logic [TICK_W-1:0] tick_q, tick_nx;
    logic [1:0]        load_q, load_nx;
    logic              done_q, done_nx;

    logic [NOTE_W-1:0] rom_q;
    logic [ADDR_W-1:0] len;
    logic              last_step;
    logic [ADDR_W:0]   step_p2;
    logic              wrap_next;
    logic [ADDR_W-1:0] first_addr;
    logic              gap;

    assign rom_q      = sel_q ? bus.rom2_note : bus.rom1_note;
    assign len        = sel_q ? LEN2_A : LEN1_A;
    assign last_step  = (step_q == len - ADDR_W'(1));
    // Address of the step after the next one; one extra bit so it cannot wrap.
    assign step_p2    = {1'b0, step_q} + (ADDR_W + 1)'(2);
    assign wrap_next  = (step_p2 == {1'b0, len});
    // Prefetch target once step 0 is sounding (a one-step song re-reads 0).
    assign first_addr = (len == ADDR_W'(1)) ? '0 : ADDR_W'(1);

    // Articulation gap: the upcoming note (already prefetched on rom_q) equals
    // the one sounding, so the last ARTIC_CYC clocks of the step are silenced.
    assign gap = GAP_EN && (32'(tick_q) >= ARTIC_START) &&
                 (rom_q == held_q) && (held_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_q  <= 1'b0;
            addr_q <= '0;
            step_q <= '0;
            held_q <= '0;
            tick_q <= '0;
            load_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sel_q  <= sel_nx;
            addr_q <= addr_nx;
            step_q <= step_nx;
            held_q <= held_nx;
            tick_q <= tick_nx;
            load_q <= load_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        addr_nx  = addr_q;
        step_nx  = step_q;
        held_nx  = held_q;
        tick_nx  = tick_q;
        load_nx  = load_q;
        done_nx  = 1'b0;

        if (bus.stop) begin
            state_nx = S_IDLE;
            addr_nx  = '0;
            step_nx  = '0;
            held_nx  = '0;
            tick_nx  = '0;
            load_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.play) begin
                        sel_nx   = bus.song_sel;
                        addr_nx  = '0;
                        load_nx  = '0;
                        state_nx = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Waits out the ROM read of step 0 before it is latched.
                    if (load_q == 2'd2) begin
                        held_nx  = rom_q;
                        step_nx  = '0;
                        addr_nx  = first_addr;
                        tick_nx  = '0;
                        state_nx = S_PLAY;
                    end else begin
                        load_nx = load_q + 2'd1;
                    end
                end
                S_PLAY: begin
                    if (bus.pause) begin
                        state_nx = S_PAUSED;
                    end else if (tick_q == TICK_LAST) begin
                        tick_nx = '0;
                        if (!last_step) begin
                            step_nx = step_q + ADDR_W'(1);
                            held_nx = rom_q;
                            addr_nx = wrap_next ? '0 : step_p2[ADDR_W-1:0];
                        end else if (bus.loop_en) begin
                            step_nx = '0;
                            held_nx = rom_q;
                            addr_nx = first_addr;
                        end else begin
                            done_nx  = 1'b1;
                            step_nx  = '0;
                            held_nx  = '0;
                            addr_nx  = '0;
                            state_nx = S_IDLE;
                        end
                    end else begin
                        tick_nx = tick_q + TICK_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (bus.play) begin
                        state_nx = S_PLAY;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Only PLAY sounds; PAUSED mutes while held_q keeps the note for resume.
    assign bus.note_out  = (state == S_PLAY && !gap) ? held_q : '0;
    assign bus.rom_addr  = addr_q;
    assign bus.step      = step_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    localparam int TD    = 4;
    localparam int L1    = 365;
    localparam int L2    = 261;
    localparam int ARTIC = 1;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    song_sequencer_if #(.ADDR_W(10), .NOTE_W(10)) bus ();

    song_sequencer #(
        .TICK_DIV (TD),
        .LEN1     (L1),
        .LEN2     (L2),
        .ADDR_W   (10),
        .NOTE_W   (10),
        .ARTIC_CYC(ARTIC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- song contents ----------------
    function automatic logic [9:0] rom_note(input bit sel, input int a);
        if (!sel) begin
            if (a < 4) return 10'd34;
            if (a == 4 || a == 5 || a == 364) return 10'd39;
            if (a < L1) return 10'(20 + (a * 7) % 50);
            return 10'd0;
        end else begin
            if (a < 4) return 10'd44;
            if (a == 4) return 10'd42;
            if (a < L2) return 10'(5 + (a * 11) % 60);
            return 10'd0;
        end
    endfunction

    // Registered ROMs, one clock of read latency.
    always @(posedge clk) begin
        bus.rom1_note <= rom_note(1'b0, int'(bus.rom_addr));
        bus.rom2_note <= rom_note(1'b1, int'(bus.rom_addr));
    end

    // ---------------- behavioural model ----------------
    // m_pos counts clocks of actual playback since the first note; the step
    // sounding is m_pos / TD. Mode: 0 idle, 1 loading, 2 playing, 3 paused.
    int m_mode, m_pos, m_load_left;
    bit m_sel, m_done;

    function automatic int song_len(input bit sel);
        return sel ? L2 : L1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_load_left = 0; m_sel = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (bus.stop) begin
                m_mode = 0; m_pos = 0;
            end else begin
                case (m_mode)
                    0: if (bus.play) begin
                        m_sel = bus.song_sel; m_mode = 1; m_load_left = 3;
                    end
                    1: begin
                        m_load_left--;
                        if (m_load_left == 0) begin m_mode = 2; m_pos = 0; end
                    end
                    2: if (bus.pause) begin
                        m_mode = 3;
                    end else begin
                        m_pos++;
                        if (m_pos / TD >= song_len(m_sel)) begin
                            m_pos = 0;
                            if (!bus.loop_en) begin m_mode = 0; m_done = 1'b1; end
                        end
                    end
                    default: if (bus.play) m_mode = 2;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int s, nx;
        logic [9:0] e_note, e_step, e_addr;
        logic e_busy, e_done;
        if (!rst && chk_en) begin
            s  = m_pos / TD;
            nx = (s + 1 >= song_len(m_sel)) ? 0 : s + 1;
            e_busy = (m_mode != 0);
            e_done = m_done;
            e_step = (m_mode >= 2) ? 10'(s) : 10'd0;
            e_addr = (m_mode >= 2) ? 10'(nx) : 10'd0;
            e_note = (m_mode == 2) ? rom_note(m_sel, s) : 10'd0;
`ifdef ARTIC_GAP_EN
            if (m_mode == 2 && (m_pos % TD) >= TD - ARTIC &&
                rom_note(m_sel, nx) == rom_note(m_sel, s) && rom_note(m_sel, s) != 0)
                e_note = 10'd0;
`endif
            n_tests++;
            if ({bus.note_out, bus.step, bus.rom_addr, bus.busy, bus.done} !==
                {e_note, e_step, e_addr, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got note=%0d step=%0d addr=%0d busy=%0b done=%0b expected note=%0d step=%0d addr=%0d busy=%0b done=%0b",
                         $time, bus.note_out, bus.step, bus.rom_addr, bus.busy, bus.done,
                         e_note, e_step, e_addr, e_busy, e_done);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_play();
        bus.play = 1'b1; @(negedge clk); bus.play = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1; @(negedge clk); bus.pause = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int done_cnt, done_at;
        rst = 1'b1;
        bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        bus.song_sel = 1'b0; bus.loop_en = 1'b0;
        wait_neg(3);
        check("reset_note", bus.note_out, 0);
        check("reset_addr", bus.rom_addr, 0);
        check("reset_step", bus.step, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        wait_neg(1);

        // Song 1 start: first note three clocks after play, step 4 16 clocks on.
        pulse_play();
        check("s1_busy", bus.busy, 1);
        wait_neg(3);
        check("s1_first_note", bus.note_out, 34);
        check("s1_first_addr", bus.rom_addr, 1);
        wait_neg(15);
        check("s1_step3_note", bus.note_out, 34);
        check("s1_step3", bus.step, 3);
        wait_neg(1);
        check("s1_step4_note", bus.note_out, 39);
        check("s1_step4", bus.step, 4);
        pulse_stop();
        check("stop_busy", bus.busy, 0);

        // Song 2; song_sel changes after acceptance must not matter.
        bus.song_sel = 1'b1;
        pulse_play();
        bus.song_sel = 1'b0;
        wait_neg(3);
        check("s2_first_note", bus.note_out, 44);
        wait_neg(16);
        check("s2_step4_note", bus.note_out, 42);
        pulse_stop();

        // Song 1 to the end without looping.
        bus.loop_en = 1'b0;
        pulse_play();
        wait_neg(3);
        done_cnt = 0; done_at = -1;
        for (int i = 1; i <= 1500; i++) begin
            @(negedge clk);
            if (i == 1459) begin
                check("end_last_step", bus.step, 364);
                check("end_last_note", bus.note_out, 39);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        check("end_done_count", done_cnt, 1);
        check("end_done_time", done_at, 1460);
        check("end_busy", bus.busy, 0);
        check("end_note", bus.note_out, 0);

        // Song 1 looping.
        bus.loop_en = 1'b1;
        pulse_play();
        wait_neg(3);
        done_cnt = 0;
        for (int i = 1; i <= 1464; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (i == 1459) check("loop_last_note", bus.note_out, 39);
            if (i == 1460) begin
                check("loop_wrap_step", bus.step, 0);
                check("loop_wrap_note", bus.note_out, 34);
            end
        end
        check("loop_no_done", done_cnt, 0);
        pulse_stop();
        bus.loop_en = 1'b0;

        // Pause at tick 1 of step 5, hold 20 clocks, resume.
        pulse_play();
        wait_neg(3);
        wait_neg(21);
        pulse_pause();
        check("pause_note", bus.note_out, 0);
        check("pause_step", bus.step, 5);
        wait_neg(19);
        check("pause_hold_step", bus.step, 5);
        check("pause_hold_busy", bus.busy, 1);
        pulse_play();
        check("resume_note", bus.note_out, 39);
        wait_neg(2);
        check("resume_step5", bus.step, 5);
        wait_neg(1);
        check("resume_step6", bus.step, 6);
        check("resume_step6_note", bus.note_out, 62);

        // stop wins over pause.
        bus.stop = 1'b1; bus.pause = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.pause = 1'b0;
        check("stoppause_busy", bus.busy, 0);
        check("stoppause_note", bus.note_out, 0);
        check("stoppause_done", bus.done, 0);
        check("stoppause_addr", bus.rom_addr, 0);
        wait_neg(5);

        // Asynchronous reset mid-step.
        pulse_play();
        wait_neg(10);
        #2 rst = 1'b1;
        #1;
        check("areset_note", bus.note_out, 0);
        check("areset_busy", bus.busy, 0);
        check("areset_step", bus.step, 0);
        check("areset_addr", bus.rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_neg(3);

        // Articulation of repeated steps 0..3 (note 34); step 3 -> 39 has no gap.
        pulse_play();
        wait_neg(3);
        wait_neg(3);
`ifdef ARTIC_GAP_EN
        check("artic_step0_tail", bus.note_out, 0);
        wait_neg(4);
        check("artic_step1_tail", bus.note_out, 0);
        wait_neg(4);
        check("artic_step2_tail", bus.note_out, 0);
        wait_neg(4);
        check("artic_step3_tail", bus.note_out, 34);
`else
        check("sustain_step0_tail", bus.note_out, 34);
        wait_neg(12);
        check("sustain_step3_tail", bus.note_out, 34);
`endif
        pulse_stop();
        wait_neg(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Tempo-driven playback controller for the two note ROMs (song 1: 365 steps, song 2: 261 steps). It walks a shared 10-bit ROM address one step per tempo tick and prefetches one step ahead to cover the ROMs' registered read. It presents the current note index to the tone generator and handles play, pause, stop, song select and looping. It sits between the user-input debouncers and the tone generator.

## Interface
- `TICK_DIV`, default 6250000: clocks per step (one sixteenth note); must be ≥ 4.
- `LEN1`, default 365: step count of song 1.
- `LEN2`, default 261: step count of song 2.
- `ADDR_W`, default 10: ROM address width.
- `NOTE_W`, default 10: note index width.
- `ARTIC_CYC`, default 500000: articulation gap length in clocks; must be ≤ `TICK_DIV`-3. Used only with `ARTIC_GAP_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `play`  in  1  single-cycle pulse: start from IDLE, resume from PAUSED.
- `pause`  in  1  single-cycle pulse: pause while PLAY.
- `stop`  in  1  single-cycle pulse: abort to IDLE from any state.
- `song_sel`  in  1  0 = song 1, 1 = song 2; sampled only on the accepted `play` in IDLE.
- `loop_en`  in  1  wrap to step 0 at end of song; sampled at each end-of-song boundary.
- `rom_addr`  out  ADDR_W  address to both ROMs.
- `rom1_note`  in  NOTE_W  ROM1 registered output.
- `rom2_note`  in  NOTE_W  ROM2 registered output.
- `note_out`  out  NOTE_W  note to tone generator; 0 = silence.
- `step`  out  ADDR_W  index of the step currently sounding.
- `busy`  out  1  high in LOAD, PLAY and PAUSED.
- `done`  out  1  one-cycle pulse when a non-looping song ends.

## Operation
- Reset values: state IDLE, `rom_addr`=0, `note_out`=0, `step`=0, `busy`=0, `done`=0, tick counter 0, `sel_q`=0.
- `rom_q` = `sel_q` ? `rom2_note` : `rom1_note`. `len` = `sel_q` ? `LEN2` : `LEN1`.
- Input priority: `stop` > `pause` > `play`.
- States:
  - IDLE: on `play`, latch `sel_q`<=`song_sel`, set `rom_addr`<=0, go to LOAD.
  - LOAD: hold for 2 cycles. At the end, set `note_out`<=`rom_q` (step 0), `step`<=0, `rom_addr`<=1 (or 0 if `len`==1), tick<=0, go to PLAY.
  - PLAY: tick counts 0..`TICK_DIV`-1.
    - At tick==`TICK_DIV`-1 and `step`<`len`-1: `step`<=`step`+1, `note_out`<=`rom_q`, `rom_addr`<=(`step`+2==`len`) ? 0 : `step`+2, tick<=0.
    - At tick==`TICK_DIV`-1 and `step`==`len`-1 with `loop_en`=1: `step`<=0, `note_out`<=`rom_q` (the prefetched step 0), `rom_addr`<=1.
    - At tick==`TICK_DIV`-1 and `step`==`len`-1 with `loop_en`=0: `done`<=1 for one cycle, `note_out`<=0, `rom_addr`<=0, go to IDLE.
    - `pause`: go to PAUSED; tick, `step` and `rom_addr` are frozen.
  - PAUSED: `note_out` muted to 0, with the held note kept internally. On `play`, restore the held note and continue from the frozen tick value.
  - `stop` in any state: next cycle IDLE, `note_out`=0, `rom_addr`=0, tick=0, `step`=0; no `done` pulse.
- `play` in LOAD or PLAY and `pause` outside PLAY are ignored.
- Switching `song_sel` mid-song has no effect until the next start from IDLE.

## Timing
- ROM read latency is one clock after `rom_addr` changes. The prefetched `rom_q` is therefore stable from tick 2 of each step.
- Latency from the `play` pulse (edge k) to the first note on `note_out`: visible after edge k+3.
- Each step lasts exactly `TICK_DIV` clocks with no slip at wrap.
- `done` rises on the same edge on which `note_out` goes to 0.
- Asynchronous reset mid-song clears everything immediately, without waiting for a clock edge.

## Configuration
- `ARTIC_GAP_EN` defined:
  - During PLAY, when tick ≥ `TICK_DIV`-`ARTIC_CYC` and `rom_q` == the held note and the held note ≠ 0, `note_out` is forced to 0.
  - This re-articulates repeated identical steps as separate notes.
  - The held note and the step boundary update are unaffected.
- `ARTIC_GAP_EN` undefined: `note_out` equals the held note throughout PLAY, so repeated steps sound as one sustained tone.

## Test plan
- Reset, `TICK_DIV`=4, `song_sel`=0, pulse `play` → `busy`=1; `note_out`=34 three clocks later; `rom_addr`=1; `note_out` stays 34 through step 3, becomes 39 at step 4 (clock 16 after first note).
- `song_sel`=1, `play` → first `note_out`=44; 4 steps later 42.
- Song 1, `loop_en`=0, run 365 steps → single `done` pulse, `note_out`=0, `busy`=0. With `loop_en`=1 → no `done`; after step 364 (`note_out`=39) comes `step`=0 with `note_out`=34.
- `pause` at tick 1 of step 5 → `note_out`=0 and `step` frozen for 20 clocks; `play` → note 39 restored, step 5 ends 3 clocks later.
- `stop` together with `pause` during PLAY → IDLE next cycle, `note_out`=0, no `done`. Reset asserted mid-step → all outputs 0 immediately.
- `ARTIC_GAP_EN`, `TICK_DIV`=4, `ARTIC_CYC`=1 → `note_out`=0 on the last clock of steps 0, 1, 2; no gap at the end of step 3 (next note 39 ≠ 34).
